// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU opcodes,
// arbiter FSM state encoding and a small index helper.
package alu_arbiter_pkg;

    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_OPCODE_SIZE = 4;

    // ALU opcodes; any other value is undefined and yields 0 from the ALU.
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_ADD = 4'd1;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_SUB = 4'd2;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_AND = 4'd3;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_OR  = 4'd4;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_XOR = 4'd5;
    localparam logic [DEF_OPCODE_SIZE-1:0] OP_NOT = 4'd6;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Increment an index modulo n (used to advance the round-robin pointer).
    function automatic int wrap_inc(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response, ALU and status signals around the arbiter.
// slave: the arbiter side. master: requesters plus the ALU (bench side).
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int OPCODE_SIZE = DEF_OPCODE_SIZE,
    parameter int CNT_WIDTH   = 16
) ();

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*OPCODE_SIZE-1:0] req_opcode;
    logic [NUM_REQ*WORD_SIZE-1:0]   req_a;
    logic [NUM_REQ*WORD_SIZE-1:0]   req_b;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [NUM_REQ-1:0]             resp_ready;
    logic [WORD_SIZE-1:0]           resp_data;
    logic [OPCODE_SIZE-1:0]         alu_opcode;
    logic [WORD_SIZE-1:0]           alu_input1;
    logic [WORD_SIZE-1:0]           alu_input2;
    logic                           alu_enable;
    logic [WORD_SIZE-1:0]           alu_out;
    logic                           busy;
    logic [CNT_WIDTH-1:0]           issue_count;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, resp_ready, alu_out,
        output req_ready, resp_valid, resp_data,
        output alu_opcode, alu_input1, alu_input2, alu_enable,
        output busy, issue_count
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, resp_ready, alu_out,
        input  req_ready, resp_valid, resp_data,
        input  alu_opcode, alu_input1, alu_input2, alu_enable,
        input  busy, issue_count
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr,
// wrapping around; rr_ptr itself has the highest priority.
module rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [IDX_W-1:0]     idx;
    int                   sum;

    // Rotate the request vector so rr_ptr lands at bit 0, then priority-scan.
    always_comb begin
        dbl   = {req_valid_i, req_valid_i};
        rot   = NUM_REQ'(dbl >> rr_ptr_i);
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(rr_ptr_i) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                idx   = IDX_W'(sum);
            end
        end
    end

    // Decode the chosen index into the one-hot grant.
    always_comb begin
        grant_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_o[j] = found && (idx == IDX_W'(j));
        end
        idx_o = idx;
        any_o = found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-output ALU between NUM_REQ requesters. Each accepted
// operation goes IDLE -> ISSUE (single alu_enable pulse) -> WAIT (ALU result
// appears) -> RESP (held until the granted requester takes it).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int OPCODE_SIZE = DEF_OPCODE_SIZE,
    parameter int CNT_WIDTH   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;
    logic [WORD_SIZE-1:0]   in1_q, in1_d;
    logic [WORD_SIZE-1:0]   in2_q, in2_d;
    logic [WORD_SIZE-1:0]   resp_data_q, resp_data_d;
    logic [CNT_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
    logic                   alu_en_q, alu_en_d;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   accept;
    logic                   resp_take;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid_i (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    assign accept    = (state_q == ARB_IDLE) && pick_any;
    assign resp_take = (state_q == ARB_RESP) && bus.resp_ready[gnt_q];

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_any)  state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  state_d = ARB_RESP;
            ARB_RESP:  if (resp_take) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: accept strobe, response valid and busy flag.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.busy       = (state_q != ARB_IDLE);
        if (state_q == ARB_IDLE && reset_n) begin
            bus.req_ready = pick_grant;
        end
        if (state_q == ARB_RESP) begin
            bus.resp_valid[gnt_q] = 1'b1;
        end
    end

    // Next values for the operand, grant, pointer, result and counter registers.
    always_comb begin
        opcode_d    = opcode_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        issue_cnt_d = issue_cnt_q;
        // alu_enable is registered from the next state so the pulse is glitch-free.
        alu_en_d    = (state_d == ARB_ISSUE);
        if (accept) begin
            opcode_d = bus.req_opcode[int'(pick_idx)*OPCODE_SIZE +: OPCODE_SIZE];
            in1_d    = bus.req_a[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];
            in2_d    = bus.req_b[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];
            gnt_d    = pick_idx;
        end
        if (state_q == ARB_ISSUE) begin
            issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
        end
        if (state_q == ARB_WAIT) begin
            resp_data_d = bus.alu_out;
        end
        if (resp_take) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(gnt_q), NUM_REQ));
        end
    end

    // Datapath and bookkeeping registers; async reset drops alu_enable at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q    <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
            issue_cnt_q <= '0;
            alu_en_q    <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
            issue_cnt_q <= issue_cnt_d;
            alu_en_q    <= alu_en_d;
        end
    end

    assign bus.alu_opcode  = opcode_q;
    assign bus.alu_input1  = in1_q;
    assign bus.alu_input2  = in2_q;
    assign bus.alu_enable  = alu_en_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.issue_count = issue_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(2), .WORD_SIZE(16), .OPCODE_SIZE(4), .CNT_WIDTH(16)) bus ();
    alu_arbiter_if #(.NUM_REQ(2), .WORD_SIZE(16), .OPCODE_SIZE(4), .CNT_WIDTH(4))  bus2 ();

    alu_arbiter #(.NUM_REQ(2), .WORD_SIZE(16), .OPCODE_SIZE(4), .CNT_WIDTH(16)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    alu_arbiter #(.NUM_REQ(2), .WORD_SIZE(16), .OPCODE_SIZE(4), .CNT_WIDTH(4)) dut2 (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    function automatic logic [15:0] alu_model(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    // Registered ALU: result appears the cycle after alu_enable.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.alu_out  <= 16'h0;
            bus2.alu_out <= 16'h0;
        end else begin
            if (bus.alu_enable)
                bus.alu_out <= alu_model(bus.alu_opcode, bus.alu_input1, bus.alu_input2);
            if (bus2.alu_enable)
                bus2.alu_out <= alu_model(bus2.alu_opcode, bus2.alu_input1, bus2.alu_input2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req_opcode[r*4 +: 4] = op;
        bus.req_a[r*16 +: 16]    = a;
        bus.req_b[r*16 +: 16]    = b;
    endtask

    initial begin
        int n;
        int cyc;
        logic [1:0]  exp_g;
        logic [15:0] exp_d;

        reset_n         = 1'b0;
        bus.req_valid   = '0;
        bus.req_opcode  = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.resp_ready  = '0;
        bus2.req_valid  = '0;
        bus2.req_opcode = '0;
        bus2.req_a      = '0;
        bus2.req_b      = '0;
        bus2.resp_ready = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   bus.busy,        0);
        chk("rst_rready", bus.req_ready,   0);
        chk("rst_rvalid", bus.resp_valid,  0);
        chk("rst_rdata",  bus.resp_data,   0);
        chk("rst_en",     bus.alu_enable,  0);
        chk("rst_op",     bus.alu_opcode,  0);
        chk("rst_in1",    bus.alu_input1,  0);
        chk("rst_cnt",    bus.issue_count, 0);
        reset_n = 1'b1;
        step();

        // Requester 0: ADD 3+4
        set_req(0, OP_ADD, 16'h0003, 16'h0004);
        bus.req_valid = 2'b01;
        #1;
        chk("t1_accept", bus.req_ready,  2'b01);
        chk("t1_en_T",   bus.alu_enable, 0);
        step();
        bus.req_valid = 2'b00;
        set_req(0, OP_SUB, 16'hDEAD, 16'hBEEF);
        chk("t1_en_T1",  bus.alu_enable, 1);
        chk("t1_op",     bus.alu_opcode, OP_ADD);
        chk("t1_in1",    bus.alu_input1, 16'h0003);
        chk("t1_in2",    bus.alu_input2, 16'h0004);
        chk("t1_busy",   bus.busy,       1);
        step();
        chk("t1_en_T2",  bus.alu_enable, 0);
        chk("t1_in1_hold", bus.alu_input1, 16'h0003);
        step();
        chk("t1_en_T3",  bus.alu_enable, 0);
        chk("t1_rvalid", bus.resp_valid, 2'b01);
        chk("t1_rdata",  bus.resp_data,  16'h0007);
        chk("t1_cnt",    bus.issue_count, 1);
        bus.resp_ready = 2'b01;
        step();
        bus.resp_ready = 2'b00;
        chk("t1_done_rv", bus.resp_valid, 0);
        chk("t1_done_busy", bus.busy,     0);

        // Requester 1: SUB 5-7
        set_req(1, OP_SUB, 16'h0005, 16'h0007);
        bus.req_valid = 2'b10;
        #1;
        chk("t2_accept", bus.req_ready, 2'b10);
        step();
        bus.req_valid = 2'b00;
        step();
        step();
        chk("t2_rvalid", bus.resp_valid,  2'b10);
        chk("t2_rdata",  bus.resp_data,   16'hFFFE);
        chk("t2_cnt",    bus.issue_count, 2);
        bus.resp_ready = 2'b10;
        step();
        bus.resp_ready = 2'b00;

        // Both requesters continuously valid after reset: grants alternate
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        set_req(0, OP_ADD, 16'h0001, 16'h0002);
        set_req(1, OP_XOR, 16'hF0F0, 16'h0FF0);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 16'h0003 : 16'hFF00;
            chk("t3_accept", bus.req_ready, exp_g);
            step();
            chk("t3_issue_rr", bus.req_ready, 0);
            chk("t3_issue_en", bus.alu_enable, 1);
            step();
            step();
            chk("t3_rvalid", bus.resp_valid, exp_g);
            chk("t3_rdata",  bus.resp_data,  exp_d);
            step();
        end
        chk("t3_cnt", bus.issue_count, 4);
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        #1;

        // Requester 0 stalls its response while requester 1 waits
        set_req(0, OP_AND, 16'hFF0F, 16'h0FF0);
        set_req(1, OP_OR,  16'h1200, 16'h0034);
        bus.req_valid = 2'b01;
        #1;
        chk("t4_accept0", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        step();
        step();
        bus.req_valid = 2'b10;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_rv", bus.resp_valid, 2'b01);
            chk("t4_hold_rd", bus.resp_data,  16'h0F00);
            chk("t4_hold_rr", bus.req_ready,  0);
            chk("t4_hold_en", bus.alu_enable, 0);
            step();
        end
        bus.resp_ready = 2'b01;
        step();
        bus.resp_ready = 2'b10;
        chk("t4_accept1", bus.req_ready, 2'b10);
        chk("t4_rv_drop", bus.resp_valid, 0);
        step();
        bus.req_valid = 2'b00;
        chk("t4_in1", bus.alu_input1, 16'h1200);
        step();
        step();
        chk("t4_rvalid1", bus.resp_valid, 2'b10);
        chk("t4_rdata1",  bus.resp_data,  16'h1234);
        step();
        bus.resp_ready = 2'b00;

        // Reset asserted during WAIT
        set_req(0, OP_ADD, 16'h0010, 16'h0020);
        bus.req_valid = 2'b01;
        #1;
        chk("t5_accept", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        step();
        chk("t5_wait_cnt", bus.issue_count, 7);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_en",   bus.alu_enable,  0);
        chk("t5_rst_busy", bus.busy,        0);
        chk("t5_rst_cnt",  bus.issue_count, 0);
        chk("t5_rst_rv",   bus.resp_valid,  0);
        reset_n = 1'b1;
        bus.resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_post_rv",   bus.resp_valid, 0);
            chk("t5_post_busy", bus.busy,       0);
        end
        bus.resp_ready = 2'b00;

        // Undefined opcode yields 0 from the ALU
        set_req(1, 4'hF, 16'h1234, 16'h5678);
        bus.req_valid = 2'b10;
        #1;
        chk("t6_accept", bus.req_ready, 2'b10);
        step();
        bus.req_valid = 2'b00;
        chk("t6_op", bus.alu_opcode, 4'hF);
        step();
        step();
        chk("t6_rvalid", bus.resp_valid, 2'b10);
        chk("t6_rdata",  bus.resp_data,  16'h0000);
        bus.resp_ready = 2'b10;
        step();
        bus.resp_ready = 2'b00;

        // 4-bit counter: 17 operations wrap to 1
        bus2.req_opcode = {4'h0, OP_ADD};
        bus2.req_a      = {16'h0, 16'h0001};
        bus2.req_b      = {16'h0, 16'h0001};
        bus2.resp_ready = 2'b01;
        bus2.req_valid  = 2'b01;
        #1;
        n = 0;
        cyc = 0;
        while (n < 17 && cyc < 200) begin
            if (bus2.req_ready[0]) n++;
            step();
            cyc++;
        end
        bus2.req_valid = 2'b00;
        chk("t7_accepts", n, 17);
        repeat (4) step();
        chk("t7_busy", bus2.busy,        0);
        chk("t7_cnt",  bus2.issue_count, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
